multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset control unit: instruction-sequencing FSM, condition
// check against a private flags register, and ALU/datapath mux selects.
`timescale 1ns/1ps

module multicycle_ctrl (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       RegWrite,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic [1:0] ALUControl,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] flags_q, flags_d;
   logic       condex_q, condex_d;

   logic       fetch, branch, reg_w, mem_w, ir_write, adr_src, src_a;
   logic [1:0] res_src, src_b, alu_ctl;
   logic       is_exec, is_cmp;

   // Flags are packed {N,Z,C,V}.
   function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      n  = f[3];
      z  = f[2];
      cy = f[1];
      v  = f[0];
      case (c)
         4'b0000: cond_eval = z;
         4'b0001: cond_eval = ~z;
         4'b0010: cond_eval = cy;
         4'b0011: cond_eval = ~cy;
         4'b0100: cond_eval = n;
         4'b0101: cond_eval = ~n;
         4'b0110: cond_eval = v;
         4'b0111: cond_eval = ~v;
         4'b1000: cond_eval = cy & ~z;
         4'b1001: cond_eval = ~cy | z;
         4'b1010: cond_eval = (n == v);
         4'b1011: cond_eval = (n != v);
         4'b1100: cond_eval = ~z & (n == v);
         4'b1101: cond_eval = z | (n != v);
         default: cond_eval = 1'b1;
      endcase
   endfunction

   function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
      case (cmd)
         4'b0100: alu_decode = 2'b00;
         4'b0010: alu_decode = 2'b01;
         4'b1010: alu_decode = 2'b01;
         4'b0000: alu_decode = 2'b10;
         4'b1100: alu_decode = 2'b11;
         default: alu_decode = 2'b00;
      endcase
   endfunction

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q  <= S_FETCH;
         flags_q  <= 4'b0000;
         condex_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         flags_q  <= flags_d;
         condex_q <= condex_d;
      end
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            case (Op)
               2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: state_d = S_MEMWB;
         S_EXECR:   state_d = S_ALUWB;
         S_EXECI:   state_d = S_ALUWB;
         default:   state_d = S_FETCH;
      endcase
   end

   always_comb begin
      fetch    = 1'b0;
      branch   = 1'b0;
      reg_w    = 1'b0;
      mem_w    = 1'b0;
      ir_write = 1'b0;
      adr_src  = 1'b0;
      src_a    = 1'b0;
      res_src  = 2'b00;
      src_b    = 2'b00;
      alu_ctl  = 2'b00;
      case (state_q)
         S_FETCH: begin
            fetch    = 1'b1;
            ir_write = 1'b1;
            src_a    = 1'b1;
            src_b    = 2'b10;
            res_src  = 2'b10;
         end
         S_DECODE: begin
            src_a   = 1'b1;
            src_b   = 2'b10;
            res_src = 2'b10;
         end
         S_MEMADR:  src_b = 2'b01;
         S_MEMREAD: adr_src = 1'b1;
         S_MEMWB: begin
            res_src = 2'b01;
            reg_w   = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src = 1'b1;
            mem_w   = 1'b1;
         end
         S_EXECR: alu_ctl = alu_decode(Funct[4:1]);
         S_EXECI: begin
            src_b   = 2'b01;
            alu_ctl = alu_decode(Funct[4:1]);
         end
         S_ALUWB: reg_w = 1'b1;
         S_BRANCH: begin
            src_b   = 2'b01;
            res_src = 2'b10;
            branch  = 1'b1;
         end
         default: ;
      endcase
   end

   // Condition is resolved once in DECODE; later states of the instruction
   // only see the latched result, so a flag update in EXEC cannot affect it.
   assign is_exec = (state_q == S_EXECR) || (state_q == S_EXECI);
   assign is_cmp  = (Funct[4:1] == 4'b1010);

   always_comb begin
      condex_d = condex_q;
      flags_d  = flags_q;
      if (state_q == S_DECODE) begin
         condex_d = cond_eval(Cond, flags_q);
      end
      if (is_exec && Funct[0] && condex_q) begin
         flags_d[3:2] = ALUFlags[3:2];
         if (!alu_ctl[1]) begin
            flags_d[1:0] = ALUFlags[1:0];
         end
      end
   end

   // Architectural strobes are gated by reset so an abandoned instruction never writes.
   assign PCWrite    = RESET_N & (fetch | (condex_q & (branch | (reg_w & (Rd == 4'hF)))));
   assign IRWrite    = RESET_N & ir_write;
   assign RegWrite   = RESET_N & reg_w & condex_q & ~is_cmp;
   assign MemWrite   = RESET_N & mem_w & condex_q;
   assign AdrSrc     = adr_src;
   assign ResultSrc  = res_src;
   assign ALUSrcA    = src_a;
   assign ALUSrcB    = src_b;
   assign ALUControl = alu_ctl;
   assign ImmSrc     = Op;
   assign RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
   assign State      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction sequences
// plus randomized instructions against an instruction-level reference model.
`timescale 1ns/1ps

module tb_multicycle_ctrl;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
   logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
   logic [3:0] State;

   int n_assert = 0;
   int n_fail   = 0;
   logic [3:0] mflags;

   multicycle_ctrl dut (
      .CLK(CLK), .RESET_N(RESET_N), .Cond(Cond), .Op(Op), .Funct(Funct),
      .Rd(Rd), .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
      .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .State(State)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Architectural condition test on flags {N,Z,C,V}.
   function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         0:  return z;
         1:  return !z;
         2:  return cy;
         3:  return !cy;
         4:  return n;
         5:  return !n;
         6:  return v;
         7:  return !v;
         8:  return cy && !z;
         9:  return !cy || z;
         10: return n == v;
         11: return n != v;
         12: return !z && (n == v);
         13: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [1:0] alu_model(input logic [3:0] cmd);
      if (cmd == 4'd4) return 2'd0;
      if (cmd == 4'd2 || cmd == 4'd10) return 2'd1;
      if (cmd == 4'd0) return 2'd2;
      if (cmd == 4'd12) return 2'd3;
      return 2'd0;
   endfunction

   // Expected output bus, same packing as obs_bus().
   function automatic logic [15:0] exp_bus(input int st, input bit pass, input logic [1:0] op,
                                           input logic [5:0] f, input logic [3:0] rd, input bit rst);
      bit writes_reg, pcw, irw, regw, memw, adr, sa;
      logic [1:0] rs, sb, ac;
      writes_reg = (st == 4) || (st == 8);
      pcw  = (st == 0) || (pass && (st == 9 || (writes_reg && rd == 4'd15)));
      irw  = (st == 0);
      regw = writes_reg && pass && (f[4:1] != 4'd10);
      memw = (st == 5) && pass;
      adr  = (st == 3) || (st == 5);
      sa   = (st <= 1);
      rs   = (st == 0 || st == 1 || st == 9) ? 2'd2 : (st == 4) ? 2'd1 : 2'd0;
      sb   = (st <= 1) ? 2'd2 : (st == 2 || st == 7 || st == 9) ? 2'd1 : 2'd0;
      ac   = (st == 6 || st == 7) ? alu_model(f[4:1]) : 2'd0;
      if (rst) begin
         pcw = 0; irw = 0; regw = 0; memw = 0;
      end
      return {pcw, adr, memw, irw, rs, sa, sb, regw, op, (op == 2'd1), (op == 2'd2), ac};
   endfunction

   function automatic logic [15:0] obs_bus();
      return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
              RegWrite, ImmSrc, RegSrc, ALUControl};
   endfunction

   // Runs one instruction from FETCH; entered and left 1ns after a rising edge.
   // rst_at >= 0 pulls RESET_N low during that cycle of the instruction.
   task automatic run_instr(input string nm, input logic [3:0] c, input logic [1:0] op,
                            input logic [5:0] f, input logic [3:0] rd, input logic [3:0] af,
                            input int rst_at);
      int  seq[$];
      bit  pass;
      Cond = c; Op = op; Funct = f; Rd = rd; ALUFlags = af;
      pass = cond_ok(c, mflags);
      seq = '{0, 1};
      case (op)
         2'd0: begin seq.push_back(f[5] ? 7 : 6); seq.push_back(8); end
         2'd1: begin
            seq.push_back(2);
            if (f[0]) begin seq.push_back(3); seq.push_back(4); end
            else seq.push_back(5);
         end
         2'd2: seq.push_back(9);
         default: ;
      endcase
      foreach (seq[k]) begin
         if (k == rst_at) RESET_N = 1'b0;
         #1;
         chk($sformatf("%s state c%0d", nm, k), {12'd0, State}, seq[k][15:0]);
         chk($sformatf("%s outs st%0d", nm, seq[k]), obs_bus(),
             exp_bus(seq[k], pass, op, f, rd, k == rst_at));
         @(posedge CLK); #1;
         if (k == rst_at) begin
            RESET_N = 1'b1;
            mflags  = 4'b0000;
            chk($sformatf("%s state after reset", nm), {12'd0, State}, 16'd0);
            return;
         end
      end
      if (op == 2'd0 && f[0] && pass) begin
         mflags[3:2] = af[3:2];
         if (alu_model(f[4:1]) < 2) mflags[1:0] = af[1:0];
      end
   endtask

   initial begin
      RESET_N = 1'b0; Cond = 4'hE; Op = 2'd0; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
      mflags = 4'b0000;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset state", {12'd0, State}, 16'd0);
      chk("reset strobes", {12'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 16'd0);
      RESET_N = 1'b1;

      run_instr("ADDI", 4'hE, 2'd0, 6'b101000, 4'd1, 4'b0000, -1);
      run_instr("ADD",  4'hE, 2'd0, 6'b001000, 4'd1, 4'b0000, -1);
      run_instr("LDR",  4'hE, 2'd1, 6'b011001, 4'd2, 4'b0000, -1);
      run_instr("CMP",  4'hE, 2'd0, 6'b010101, 4'd0, 4'b0100, -1);
      run_instr("BEQ",  4'h0, 2'd2, 6'b000000, 4'd0, 4'b0000, -1);
      run_instr("BNE",  4'h1, 2'd2, 6'b000000, 4'd0, 4'b0000, -1);
      run_instr("STRne", 4'h1, 2'd1, 6'b011000, 4'd3, 4'b0000, -1);
      run_instr("STR",  4'hE, 2'd1, 6'b011000, 4'd3, 4'b0000, -1);
      run_instr("UNDEF", 4'hE, 2'd3, 6'b000000, 4'd0, 4'b0000, -1);
      run_instr("ADDpc", 4'hE, 2'd0, 6'b001000, 4'd15, 4'b0000, -1);
      run_instr("ANDS", 4'hE, 2'd0, 6'b000001, 4'd4, 4'b1011, -1);
      run_instr("BCS",  4'h2, 2'd2, 6'b000000, 4'd0, 4'b0000, -1);
      run_instr("CMP2", 4'hE, 2'd0, 6'b010101, 4'd0, 4'b0100, -1);
      run_instr("STRrst", 4'hE, 2'd1, 6'b011000, 4'd3, 4'b0000, 3);
      run_instr("BEQ0", 4'h0, 2'd2, 6'b000000, 4'd0, 4'b0000, -1);
      run_instr("BNE0", 4'h1, 2'd2, 6'b000000, 4'd0, 4'b0000, -1);

      for (int i = 0; i < 300; i++) begin
         logic [3:0] rc, rrd, raf;
         logic [1:0] rop;
         logic [5:0] rf;
         int ra;
         rc  = 4'($urandom_range(0, 15));
         rop = 2'($urandom_range(0, 3));
         rf  = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) rf[4:1] = 4'b1010;
         rrd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
         raf = 4'($urandom_range(0, 15));
         ra  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 4) : -1;
         run_instr($sformatf("rnd%0d", i), rc, rop, rf, rrd, raf, ra);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
